// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the control-flow inputs and status outputs of the
// program-counter sequencer.
//   STALL     - hold all sequencer state when 1
//   FLOW_OP   - flow operation: SEQ, JUMP, BEQ, BNE, CALL, RET (110/111 act as SEQ)
//   ZERO      - ALU zero flag, qualifies BEQ/BNE
//   OFFSET    - two's-complement word offset for JUMP/branch/CALL targets
//   PC        - registered program counter
//   TAKEN     - next PC is not the sequential PC+4
//   RAS_EMPTY - return-address stack holds no entries
//   RAS_FULL  - return-address stack holds RAS_DEPTH entries
//   RAS_ERR   - sticky stack overflow/underflow flag
// The master modport is the instruction-issue side, slave is the sequencer.
interface pc_sequencer_if #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 8
);
   logic                STALL;
   logic [2:0]          FLOW_OP;
   logic                ZERO;
   logic [OFFSET_W-1:0] OFFSET;
   logic [ADDR_W-1:0]   PC;
   logic                TAKEN;
   logic                RAS_EMPTY;
   logic                RAS_FULL;
   logic                RAS_ERR;

   modport master (
      output STALL, FLOW_OP, ZERO, OFFSET,
      input  PC, TAKEN, RAS_EMPTY, RAS_FULL, RAS_ERR
   );

   modport slave (
      input  STALL, FLOW_OP, ZERO, OFFSET,
      output PC, TAKEN, RAS_EMPTY, RAS_FULL, RAS_ERR
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
//   CLK   - clock, all state updates on the rising edge
//   RESET - synchronous active-high reset, priority over STALL and FLOW_OP
//   bus   - pc_sequencer_if slave modport (STALL, FLOW_OP, ZERO, OFFSET in;
//           PC, TAKEN, RAS_EMPTY, RAS_FULL, RAS_ERR out)
// Next PC is PC+4 or PC+4+(OFFSET<<2), or the top of the return stack for RET.
// The stack keeps the most recent RAS_DEPTH return addresses; a CALL while
// full overwrites the oldest one and raises the sticky RAS_ERR.
module pc_sequencer #(
   parameter int ADDR_W    = 32,
   parameter int OFFSET_W  = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic           CLK,
   input  logic           RESET,
   pc_sequencer_if.slave  bus
);

   localparam int SP_W  = $clog2(RAS_DEPTH);
   localparam int CNT_W = SP_W + 1;

   typedef enum logic [2:0] {
      OP_SEQ  = 3'b000,
      OP_JUMP = 3'b001,
      OP_BEQ  = 3'b010,
      OP_BNE  = 3'b011,
      OP_CALL = 3'b100,
      OP_RET  = 3'b101
   } flow_op_t;

   // Branch target with plain modulo-2^ADDR_W wrap (no saturation).
   function automatic logic [ADDR_W-1:0] calc_target(
      input logic [ADDR_W-1:0]          seq,
      input logic signed [OFFSET_W-1:0] ofs
   );
      logic signed [ADDR_W-1:0] ofs_sx;
      ofs_sx = ADDR_W'(ofs);
      return seq + $unsigned(ofs_sx <<< 2);
   endfunction

   logic [ADDR_W-1:0]        pc_q;
   logic [ADDR_W-1:0]        ras_mem [RAS_DEPTH];
   logic [SP_W-1:0]          sp_q;
   logic [CNT_W-1:0]         cnt_q;
   logic                     err_q;

   logic signed [OFFSET_W-1:0] ofs_s;
   logic [ADDR_W-1:0]        seq_pc;
   logic [ADDR_W-1:0]        target;
   logic [ADDR_W-1:0]        top;
   logic [ADDR_W-1:0]        next_pc;
   logic                     ras_empty;
   logic                     ras_full;
   logic                     taken;
   logic                     do_push;
   logic                     do_pop;
   logic                     underflow;
   logic                     advance;
   flow_op_t                 op;

   assign ofs_s     = $signed(bus.OFFSET);
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
   assign top       = ras_mem[sp_q - SP_W'(1)];
   assign advance   = !RESET && !bus.STALL;

   always_comb begin
      seq_pc    = pc_q + ADDR_W'(4);
      target    = calc_target(seq_pc, ofs_s);
      next_pc   = seq_pc;
      taken     = 1'b0;
      do_push   = 1'b0;
      do_pop    = 1'b0;
      underflow = 1'b0;
      op        = flow_op_t'(bus.FLOW_OP);
      case (op)
         OP_JUMP: taken = 1'b1;
         OP_BEQ:  taken = bus.ZERO;
         OP_BNE:  taken = !bus.ZERO;
         OP_CALL: begin
            taken   = 1'b1;
            do_push = 1'b1;
         end
         OP_RET: begin
            // An empty-stack RET falls through to PC+4 and flags an error.
            if (!ras_empty) begin
               taken  = 1'b1;
               do_pop = 1'b1;
            end else begin
               underflow = 1'b1;
            end
         end
         default: taken = 1'b0;
      endcase
      if (taken) begin
         next_pc = (op == OP_RET) ? top : target;
      end
   end

   // Control state: PC, stack pointer, count and sticky error.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pc_q  <= '0;
         sp_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (!bus.STALL) begin
         pc_q <= next_pc;
         if (do_push) begin
            // sp_q always points at the next free slot; when full that slot
            // is the oldest entry, so the wrap overwrites it.
            sp_q <= sp_q + SP_W'(1);
            if (ras_full) begin
               err_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (do_pop) begin
            sp_q  <= sp_q - SP_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (underflow) begin
            err_q <= 1'b1;
         end
      end
   end

   // Stack storage: data only, never cleared.
   always_ff @(posedge CLK) begin
      if (advance && do_push) begin
         ras_mem[sp_q] <= seq_pc;
      end
   end

   assign bus.PC        = pc_q;
   assign bus.TAKEN     = taken;
   assign bus.RAS_EMPTY = ras_empty;
   assign bus.RAS_FULL  = ras_full;
   assign bus.RAS_ERR   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives directed and random flow operations into
// pc_sequencer, predicts every cycle's outputs with a queue-based model of
// the return stack, and checks them from an independent monitor.
module tb_pc_sequencer;

   localparam int ADDR_W    = 32;
   localparam int OFFSET_W  = 8;
   localparam int RAS_DEPTH = 4;

   localparam logic [2:0] SEQ  = 3'd0;
   localparam logic [2:0] JUMP = 3'd1;
   localparam logic [2:0] BEQ  = 3'd2;
   localparam logic [2:0] BNE  = 3'd3;
   localparam logic [2:0] CALL = 3'd4;
   localparam logic [2:0] RET  = 3'd5;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   pc_sequencer_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) bus ();

   pc_sequencer #(
      .ADDR_W   (ADDR_W),
      .OFFSET_W (OFFSET_W),
      .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        taken;
      logic [31:0] pc;
      logic        empty;
      logic        full;
      logic        err;
      string       tag;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc = '0;
   logic [31:0] m_ras[$];
   logic        m_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic stall, input logic [2:0] op,
                       input logic z, input logic [7:0] ofs, input string tag);
      exp_t        e;
      logic [31:0] seq;
      logic [31:0] tgt;
      @(negedge CLK);
      RESET       = rst;
      bus.STALL   = stall;
      bus.FLOW_OP = op;
      bus.ZERO    = z;
      bus.OFFSET  = ofs;
      // TAKEN depends on the state before this edge.
      e.taken = (op == JUMP) || (op == CALL) || (op == BEQ && z) ||
                (op == BNE && !z) || (op == RET && m_ras.size() != 0);
      if (rst) begin
         m_pc = '0;
         m_ras.delete();
         m_err = 1'b0;
      end else if (!stall) begin
         seq = m_pc + 32'd4;
         tgt = seq + 32'(4 * int'($signed(ofs)));
         case (op)
            JUMP: m_pc = tgt;
            BEQ:  m_pc = z ? tgt : seq;
            BNE:  m_pc = z ? seq : tgt;
            CALL: begin
               m_ras.push_back(seq);
               if (m_ras.size() > RAS_DEPTH) begin
                  void'(m_ras.pop_front());
                  m_err = 1'b1;
               end
               m_pc = tgt;
            end
            RET: begin
               if (m_ras.size() != 0) begin
                  m_pc = m_ras.pop_back();
               end else begin
                  m_err = 1'b1;
                  m_pc  = seq;
               end
            end
            default: m_pc = seq;
         endcase
      end
      e.pc    = m_pc;
      e.empty = (m_ras.size() == 0);
      e.full  = (m_ras.size() == RAS_DEPTH);
      e.err   = m_err;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: TAKEN sampled mid-cycle, registered state just after the edge.
   initial begin
      exp_t e;
      logic tk;
      forever begin
         @(negedge CLK);
         #2;
         tk = bus.TAKEN;
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".taken"}, 32'(tk), 32'(e.taken));
            chk({e.tag, ".pc"}, bus.PC, e.pc);
            chk({e.tag, ".empty"}, 32'(bus.RAS_EMPTY), 32'(e.empty));
            chk({e.tag, ".full"}, 32'(bus.RAS_FULL), 32'(e.full));
            chk({e.tag, ".err"}, 32'(bus.RAS_ERR), 32'(e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int wait_cnt;
      bus.STALL   = 1'b0;
      bus.FLOW_OP = SEQ;
      bus.ZERO    = 1'b0;
      bus.OFFSET  = '0;

      // Reset and sequential counting: 0, 4, 8, 12, then 0x10
      step(1, 0, SEQ, 0, 8'h00, "reset");
      step(0, 0, SEQ, 0, 8'h00, "seq1");
      step(0, 0, SEQ, 0, 8'h00, "seq2");
      step(0, 0, SEQ, 0, 8'h00, "seq3");
      step(0, 0, SEQ, 0, 8'h00, "seq4");
      // BEQ from 0x10: taken to 0x0C, then back to 0x10 and not taken to 0x14
      step(0, 0, BEQ, 1, 8'hFE, "beq_taken");
      step(0, 0, SEQ, 0, 8'h00, "seq_back");
      step(0, 0, BEQ, 0, 8'hFE, "beq_fall");
      // JUMP to 0x20, CALL to 0x64 pushing 0x24, RET to 0x24
      step(0, 0, JUMP, 0, 8'h02, "jump20");
      step(0, 0, CALL, 0, 8'h10, "call");
      step(0, 0, RET, 0, 8'h00, "ret");
      // Five nested CALLs then five RETs, overflow drops the oldest
      for (int i = 0; i < 5; i++) step(0, 0, CALL, 0, 8'h04, $sformatf("ncall%0d", i));
      for (int i = 0; i < 5; i++) step(0, 0, RET, 0, 8'h00, $sformatf("nret%0d", i));
      // Stalled CALL for 3 cycles, then exactly one push
      step(1, 0, SEQ, 0, 8'h00, "reset2");
      for (int i = 0; i < 3; i++) step(0, 1, CALL, 0, 8'h08, $sformatf("stall%0d", i));
      step(0, 0, CALL, 0, 8'h08, "stall_rel");
      step(0, 0, RET, 0, 8'h00, "stall_ret");
      step(0, 0, RET, 0, 8'h00, "stall_ret_empty");
      // Wrap-around: reach 0xFFFFFFFC then SEQ to 0; RESET beats STALL
      step(1, 0, SEQ, 0, 8'h00, "reset3");
      step(0, 0, JUMP, 0, 8'hFE, "jump_neg");
      step(0, 0, SEQ, 0, 8'h00, "wrap");
      step(0, 0, SEQ, 0, 8'h00, "seq_after_wrap");
      step(1, 1, CALL, 0, 8'h10, "reset_stall");
      // Reset mid-sequence discards stack entries
      step(0, 0, CALL, 0, 8'h03, "pre_rst_call");
      step(1, 0, SEQ, 0, 8'h00, "mid_reset");
      step(0, 0, RET, 0, 8'h00, "ret_after_reset");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
              3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom),
              $sformatf("rnd%0d", i));
      end

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge CLK);
         wait_cnt++;
      end
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
